if_stage: RTL and testbench

Instruction-fetch stage; master end of the IF2ID_if bus consumed by the decode stage. Owns the PC register and a request/grant/response port to instruction memory with one outstanding request. Owns the IF/ID pipeline register and a 1-entry skid buffer. Honours stall from hazard logic and PC redirect/flush from branch/jump resolution in EX.

---
 rtl/if_stage_pkg.sv | 34 +++
 rtl/if_stage_if.sv | 17 +
 rtl/if_stage_skid.sv | 37 +++
 rtl/if_stage.sv | 164 ++++++++++++++++
 tb/tb_if_stage.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/if_stage_pkg.sv
// ============================================================================
// core_pkg : shared types and defaults for the instruction-fetch stage
// Rev 1.0
// ============================================================================
`default_nettype none

package core_pkg;

  localparam int DATA_WIDTH = 32;

  localparam logic [DATA_WIDTH-1:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [DATA_WIDTH-1:0] NOP_INSTR_DEF = 32'h0000_0013;
  localparam logic [DATA_WIDTH-1:0] PC_STEP       = 32'h0000_0004;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } if_state_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] pc_plus4;
    logic [DATA_WIDTH-1:0] instruction;
  } if2id_data_t;

  function automatic logic [DATA_WIDTH-1:0] word_align(input logic [DATA_WIDTH-1:0] addr);
    return addr & ~(DATA_WIDTH'(3));
  endfunction

endpackage

`default_nettype wire

// File: rtl/if_stage_if.sv
// ============================================================================
// IF2ID_if : IF/ID pipeline bus from fetch (MASTER) to decode (SLAVE)
// Rev 1.0
// ============================================================================
`default_nettype none

interface IF2ID_if;

  core_pkg::if2id_data_t data;
  logic                  valid;

  modport MASTER (output data, output valid);
  modport SLAVE  (input  data, input  valid);

endinterface

`default_nettype wire

// File: rtl/if_stage_skid.sv
// ============================================================================
// if_skid_buffer : one-entry holding slot for a fetch that lands during stall
// Rev 1.0
// ============================================================================
`default_nettype none

module if_skid_buffer
  import core_pkg::*;
(
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        push,
  input  wire logic        pop,
  input  wire logic        flush,
  input  wire if2id_data_t din,
  output      if2id_data_t dout,
  output      logic        full
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= 1'b0;
      dout <= '0;
    end else if (flush) begin
      full <= 1'b0;
    end else if (push) begin
      // push wins over pop so a same-cycle drain and refill keeps the slot full
      full <= 1'b1;
      dout <= din;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/if_stage.sv
// ============================================================================
// if_stage : PC, one-outstanding imem fetch port, IF/ID register and skid.
// Optional IF_PERF_CNT_EN adds fetch/stall performance counters.  Rev 1.0
// ============================================================================
`default_nettype none

module if_stage
  import core_pkg::*;
#(
  parameter logic [DATA_WIDTH-1:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic                  stall_i,
  input  wire logic                  redirect_i,
  input  wire logic [DATA_WIDTH-1:0] redirect_pc_i,
  output      logic                  imem_req_o,
  output      logic [DATA_WIDTH-1:0] imem_addr_o,
  input  wire logic                  imem_gnt_i,
  input  wire logic                  imem_rvalid_i,
  input  wire logic [DATA_WIDTH-1:0] imem_rdata_i,
  IF2ID_if.MASTER                    bus_out
`ifdef IF_PERF_CNT_EN
  ,
  output      logic [31:0]           perf_fetch_o,
  output      logic [31:0]           perf_stall_o
`endif
);

  if_state_e             state, state_nxt;
  logic [DATA_WIDTH-1:0] pc_q, pc_nxt;
  logic [DATA_WIDTH-1:0] addr_q, addr_nxt;
  logic [DATA_WIDTH-1:0] inflight_pc;
  logic                  kill_q, kill_nxt;
  logic                  stale_q, stale_nxt;
  if2id_data_t           out_q;
  logic                  out_valid_q;

  logic                  grant, rsp, deliver, drain, load_rsp, push;
  logic                  skid_full, skid_full_nxt;
  if2id_data_t           skid_dout, rsp_data;
  logic [DATA_WIDTH-1:0] target;

  assign target   = word_align(redirect_pc_i);
  assign grant    = (state == S_REQ) && imem_gnt_i;
  assign rsp      = (state == S_WAIT) && imem_rvalid_i;
  assign deliver  = rsp && !kill_q && !redirect_i;
  assign drain    = skid_full && !stall_i && !redirect_i;
  assign load_rsp = deliver && !drain && (!out_valid_q || !stall_i);
  assign push     = deliver && !load_rsp;
  assign rsp_data = '{pc: inflight_pc, pc_plus4: inflight_pc + PC_STEP, instruction: imem_rdata_i};

  always_comb begin
    skid_full_nxt = skid_full;
    if (redirect_i)  skid_full_nxt = 1'b0;
    else if (push)   skid_full_nxt = 1'b1;
    else if (drain)  skid_full_nxt = 1'b0;
  end

  if_skid_buffer u_skid (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (drain),
    .flush (redirect_i),
    .din   (rsp_data),
    .dout  (skid_dout),
    .full  (skid_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      pc_q        <= RESET_PC;
      addr_q      <= RESET_PC;
      inflight_pc <= '0;
      kill_q      <= 1'b0;
      stale_q     <= 1'b0;
    end else begin
      state   <= state_nxt;
      pc_q    <= pc_nxt;
      addr_q  <= addr_nxt;
      kill_q  <= kill_nxt;
      stale_q <= stale_nxt;
      if (grant) inflight_pc <= addr_q;
    end
  end

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc_q;
    kill_nxt   = kill_q;
    stale_nxt  = stale_q;
    imem_req_o = 1'b0;
    case (state)
      S_IDLE: state_nxt = S_REQ;
      S_REQ: begin
        imem_req_o = 1'b1;
        if (imem_gnt_i) begin
          // a request redirected while waiting for grant is fetched but killed
          state_nxt = S_WAIT;
          kill_nxt  = redirect_i || stale_q;
          stale_nxt = 1'b0;
          pc_nxt    = stale_q ? pc_q : pc_q + PC_STEP;
        end else if (redirect_i) begin
          stale_nxt = 1'b1;
        end
      end
      S_WAIT: begin
        if (imem_rvalid_i) begin
          kill_nxt  = 1'b0;
          state_nxt = skid_full_nxt ? S_HOLD : S_REQ;
        end else if (redirect_i) begin
          kill_nxt = 1'b1;
        end
      end
      S_HOLD: if (!skid_full_nxt) state_nxt = S_REQ;
      default: state_nxt = S_IDLE;
    endcase
    if (redirect_i) pc_nxt = target;
  end

  // the address shown to memory must not move while a request awaits grant
  assign addr_nxt    = ((state == S_REQ) && !imem_gnt_i) ? addr_q : pc_nxt;
  assign imem_addr_o = addr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_q       <= '{pc: '0, pc_plus4: '0, instruction: NOP_INSTR};
    end else if (redirect_i) begin
      out_valid_q       <= 1'b0;
      out_q.instruction <= NOP_INSTR;
    end else if (drain) begin
      out_valid_q <= 1'b1;
      out_q       <= skid_dout;
    end else if (load_rsp) begin
      out_valid_q <= 1'b1;
      out_q       <= rsp_data;
    end else if (!stall_i) begin
      out_valid_q       <= 1'b0;
      out_q.instruction <= NOP_INSTR;
    end
  end

  assign bus_out.valid = out_valid_q;
  assign bus_out.data  = out_q;

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_o <= '0;
      perf_stall_o <= '0;
    end else begin
      if (deliver)                perf_fetch_o <= perf_fetch_o + 32'd1;
      if (stall_i && out_valid_q) perf_stall_o <= perf_stall_o + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// ============================================================================
// tb_if_stage : directed + randomized bench for if_stage against a stream model
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_if_stage;
  import core_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i, redirect_i, imem_gnt_i, imem_rvalid_i, imem_req_o;
  logic [31:0] redirect_pc_i, imem_addr_o, imem_rdata_i;

  IF2ID_if bus ();

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch, perf_stall;
`endif

  if_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .bus_out       (bus)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetch_o  (perf_fetch),
    .perf_stall_o  (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          consumed = 0;
  int          grants = 0;
  logic        drv_gnt, drv_stall, drv_redirect;
  logic [31:0] drv_rpc;
  int          dmin, dmax;
  logic        pend;
  int          pend_cnt;
  logic [31:0] pend_addr;
  logic [31:0] exp_pc;
  logic        prev_hold;
  logic [31:0] prev_addr;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    if (a == 32'hC) return 32'h00A0_0113;
    return a * 32'h9E37_79B1 + 32'h13;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // one clock: drive inputs, check pre-edge, advance the model, check post-edge
  task automatic step();
    logic        did_redirect, did_hold;
    if2id_data_t pre_data;
    imem_gnt_i    = drv_gnt;
    stall_i       = drv_stall;
    redirect_i    = drv_redirect;
    redirect_pc_i = drv_rpc;
    imem_rvalid_i = pend && (pend_cnt == 0);
    imem_rdata_i  = imem_rvalid_i ? mem_f(pend_addr) : $urandom;
    #1;
    if (prev_hold) begin
      check("req_held", {31'b0, imem_req_o}, 32'd1);
      check("addr_stable", imem_addr_o, prev_addr);
    end
    if (pend)       check("one_outstanding", {31'b0, imem_req_o}, 32'd0);
    if (imem_req_o) check("addr_aligned", imem_addr_o & 32'd3, 32'd0);
    pre_data     = bus.data;
    did_redirect = redirect_i;
    did_hold     = stall_i && bus.valid && !redirect_i;
    if (bus.valid && !stall_i && !redirect_i) begin
      check("pc", bus.data.pc, exp_pc);
      check("pc_plus4", bus.data.pc_plus4, exp_pc + 32'd4);
      check("instr", bus.data.instruction, mem_f(exp_pc));
      exp_pc = exp_pc + 32'd4;
      consumed++;
    end
    if (redirect_i) exp_pc = redirect_pc_i & ~32'd3;
    if (imem_rvalid_i)      pend = 1'b0;
    else if (pend)          pend_cnt--;
    prev_hold = imem_req_o && !imem_gnt_i;
    prev_addr = imem_addr_o;
    if (imem_req_o && imem_gnt_i) begin
      pend      = 1'b1;
      pend_addr = imem_addr_o;
      pend_cnt  = $urandom_range(dmax, dmin) - 1;
      grants++;
    end
    @(posedge clk);
    @(negedge clk);
    if (did_redirect) begin
      check("flush_valid", {31'b0, bus.valid}, 32'd0);
      check("flush_nop", bus.data.instruction, NOP);
    end
    if (did_hold) begin
      check("hold_valid", {31'b0, bus.valid}, 32'd1);
      check("hold_pc", bus.data.pc, pre_data.pc);
      check("hold_instr", bus.data.instruction, pre_data.instruction);
    end
  endtask

  initial begin
    int c0, g0, n;
    rst = 1'b1;
    stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
    drv_gnt = 1'b0; drv_stall = 1'b0; drv_redirect = 1'b0; drv_rpc = '0;
    dmin = 1; dmax = 1; pend = 1'b0; pend_cnt = 0; pend_addr = '0;
    exp_pc = 32'h0; prev_hold = 1'b0; prev_addr = '0;
    @(negedge clk); @(negedge clk);
    check("rst_req", {31'b0, imem_req_o}, 32'd0);
    check("rst_addr", imem_addr_o, 32'h0);
    check("rst_valid", {31'b0, bus.valid}, 32'd0);
    check("rst_pc", bus.data.pc, 32'h0);
    check("rst_pc4", bus.data.pc_plus4, 32'h0);
    check("rst_instr", bus.data.instruction, NOP);
    rst = 1'b0;

    // first fetch latency
    drv_gnt = 1'b1;
    step();
    check("first_req", {31'b0, imem_req_o}, 32'd1);
    check("first_addr", imem_addr_o, 32'h0);
    step();
    check("lat_not_yet", {31'b0, bus.valid}, 32'd0);
    step();
    check("lat_valid", {31'b0, bus.valid}, 32'd1);
    check("lat_pc", bus.data.pc, 32'h0);
    check("lat_instr", bus.data.instruction, 32'h0050_0093);
    check("next_addr", imem_addr_o, 32'h4);

    // grant withheld for three cycles
    step(); step();
    drv_gnt = 1'b0;
    repeat (3) step();
    check("wait_req", {31'b0, imem_req_o}, 32'd1);
    check("wait_addr", imem_addr_o, 32'h8);
    drv_gnt = 1'b1;
    step();

    // stall while the next response lands: it must park in the skid
    drv_stall = 1'b1;
    g0 = grants;
    repeat (6) step();
    check("stall_grants", grants - g0, 32'd1);
    check("stall_no_req", {31'b0, imem_req_o}, 32'd0);
    check("stall_out_pc", bus.data.pc, 32'h8);
    drv_stall = 1'b0;
    step();
    check("skid_pc", bus.data.pc, 32'hC);
    check("skid_instr", bus.data.instruction, 32'h00A0_0113);
    check("skid_next_req", {31'b0, imem_req_o}, 32'd1);
    check("skid_next_addr", imem_addr_o, 32'h10);

    // redirect while waiting on memory
    dmin = 3; dmax = 3;
    step();
    drv_redirect = 1'b1; drv_rpc = 32'h0000_0102;
    step();
    drv_redirect = 1'b0;
    n = 0;
    while (!imem_req_o && n < 10) begin step(); n++; end
    check("redirect_req", {31'b0, imem_req_o}, 32'd1);
    check("redirect_addr", imem_addr_o, 32'h100);

    // address wrap at the top of memory
    dmin = 1; dmax = 1;
    drv_redirect = 1'b1; drv_rpc = 32'hFFFF_FFFC;
    step();
    drv_redirect = 1'b0;
    c0 = consumed;
    repeat (10) step();
    check("wrap_progress", {31'b0, (consumed - c0) >= 2}, 32'd1);

    // asynchronous reset while a fetch is outstanding
    drv_stall = 1'b1; dmin = 4; dmax = 4;
    n = 0;
    while (!(pend && bus.valid) && n < 20) begin step(); n++; end
    check("pre_rst_valid", {31'b0, bus.valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_req", {31'b0, imem_req_o}, 32'd0);
    check("arst_addr", imem_addr_o, 32'h0);
    check("arst_valid", {31'b0, bus.valid}, 32'd0);
    check("arst_instr", bus.data.instruction, NOP);
    @(negedge clk);
    rst = 1'b0;
    exp_pc = 32'h0; prev_hold = 1'b0;
    pend_cnt = 0;
    drv_gnt = 1'b0; drv_stall = 1'b0;
    repeat (3) begin
      step();
      check("late_rsp_ignored", {31'b0, bus.valid}, 32'd0);
    end

    // randomized traffic
    dmin = 1; dmax = 3;
    c0 = consumed;
    for (int i = 0; i < 2000; i++) begin
      drv_gnt      = ($urandom % 4) != 0;
      drv_stall    = ($urandom % 4) == 0;
      drv_redirect = ($urandom % 24) == 0;
      drv_rpc      = (($urandom % 4) == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom;
      step();
    end
    check("random_progress", {31'b0, (consumed - c0) >= 150}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
